eight_to_three_encoder_seq: RTL and testbench
=============================================

// Module: eight_to_three_encoder_seq
// PURPOSE
//   Sequential 8-to-3 encoder, inverse of the 3-to-8 decoder. Accepts an 8-bit request vector.
//   Emits the 3-bit index of each set bit, one code per output handshake, until the batch drains.
//   Sits between a request/interrupt source and any consumer that wants binary indices.
// PARAMETERS
//   N_IN    8                number of request lines (block is verified for 8 only)
//   CODE_W  $clog2(N_IN)=3   width of emitted code
// PORTS
//   clk         in   1        single clock, rising edge
//   rst         in   1        synchronous, active-high reset
//   req_in      in   N_IN     request vector; bit i encodes to code i
//   req_valid   in   1        req_in valid
//   req_ready   out  1        block can accept a vector (high only in IDLE)
//   code        out  CODE_W   encoded index
//   code_valid  out  1        code valid
//   code_ready  in   1        consumer accepts code
//   pending     out  N_IN     bits of current batch not yet emitted
//   busy        out  1        state != IDLE
// BEHAVIOUR
//   Reset: while rst is sampled high, the block goes to IDLE. After that edge:
//     code=0, code_valid=0, pending=0, busy=0, req_ready=1.
//     All inputs are ignored in a cycle where rst=1.
//   Outputs: code, code_valid and pending are registered; req_ready and busy decode the state register.
//   FSM states: IDLE, ENCODE, HOLD.
//   IDLE: req_ready=1.
//     req_valid&&req_ready with req_in!=0: pending<=req_in, go to ENCODE.
//     req_in==0: vector is consumed, nothing is emitted, stay in IDLE.
//   ENCODE (1 cycle): search pending for the selected index; code<=idx, code_valid<=1, go to HOLD.
//   HOLD: code and code_valid hold stable until code_ready.
//     On code_valid&&code_ready: clear pending[code], code_valid<=0.
//     Go to ENCODE if the post-clear pending!=0, else go to IDLE.
//   Latency: code_valid rises 2 clocks after the input handshake.
//     Each later code follows 2 clocks after the previous output handshake (1 bubble).
//   Simultaneous events: in HOLD, req_valid is ignored (req_ready=0). No new vector merges into a batch.
//   Reset mid-operation: the batch is dropped. code_valid falls on the next edge and pending clears.
//   Widths: code is the bit index, zero-extended to CODE_W. No arithmetic overflow is possible.
// CONFIGURATION
//   Macro ROUND_ROBIN_EN.
//   Undefined: fixed priority, highest set index first.
//     Example: 8'b1010_0101 emits 7,5,2,0.
//   Defined: round-robin order.
//     last_idx register, reset 3'd7, updated to code on each output handshake.
//     last_idx persists across batches.
//     Search runs upward from last_idx+1 (mod 8) and picks the first set bit, wrapping.
//     Example after reset: 8'b1010_0101 emits 0,2,5,7.
// STRUCTURE
//   Shared header encoder_defs.vh:
//     state encodings ST_IDLE=2'd0, ST_ENCODE=2'd1, ST_HOLD=2'd2
//     N_IN / CODE_W defaults
//   Sub-module prio_find8: combinational, inputs vec[7:0] and start[2:0].
//     Outputs idx[2:0] and found.
//     Fixed-priority mode uses a descending search and ignores start.
//   Top holds the FSM, the pending register, the code/code_valid registers and last_idx.
// TESTING
//   1 rst=1 for 2 clks -> code_valid=0, pending=0, busy=0, req_ready=1.
//   2 req_in=8'b0000_1000 with valid, code_ready=1 ->
//     code=3 and code_valid=1 exactly 2 clks after accept; IDLE the clk after the handshake.
//   3 req_in=8'b1010_0101, code_ready=1 -> codes 7,5,2,0 (RR build: 0,2,5,7).
//     req_ready=0 until the last handshake; pending shrinks one bit per code.
//   4 code_ready=0 for 5 clks in HOLD -> code, code_valid and pending stable; resumes on code_ready=1.
//   5 req_in=8'h00 with valid -> accepted, no code_valid, stays IDLE.
//     A req_valid during HOLD is not accepted.
//   6 rst=1 in HOLD with pending=8'b0110_0000 -> next clk code_valid=0, pending=0, req_ready=1.

Source files
------------

// File: rtl/eight_to_three_encoder_seq_pkg.sv
// Shared types and constants for the sequential 8-to-3 encoder.
// Build option: ROUND_ROBIN_EN selects round-robin search order instead of fixed priority.
package eight_to_three_encoder_seq_pkg;

    localparam int N_IN   = 8;
    localparam int CODE_W = $clog2(N_IN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Drop one emitted index from the batch.
    function automatic logic [N_IN-1:0] clear_bit(input logic [N_IN-1:0] vec,
                                                  input logic [CODE_W-1:0] idx);
        logic [N_IN-1:0] mask;
        mask = N_IN'(1) << idx;
        return vec & ~mask;
    endfunction

endpackage

// File: rtl/eight_to_three_encoder_seq_if.sv
// Request/code handshake bundle between a request source, the encoder and a code consumer.
// Build option: ROUND_ROBIN_EN (no effect on this interface).
interface eight_to_three_encoder_seq_if;
    import eight_to_three_encoder_seq_pkg::*;

    logic [N_IN-1:0]   req_in;
    logic              req_valid;
    logic              req_ready;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;
    logic [N_IN-1:0]   pending;
    logic              busy;

    modport master (
        output req_in, req_valid, code_ready,
        input  req_ready, code, code_valid, pending, busy
    );

    modport slave (
        input  req_in, req_valid, code_ready,
        output req_ready, code, code_valid, pending, busy
    );

endinterface

// File: rtl/eight_to_three_encoder_seq_prio_find8.sv
// Combinational set-bit finder over an 8-bit vector.
// Build option: ROUND_ROBIN_EN searches upward from start with wrap; otherwise highest index wins.
module prio_find8
    import eight_to_three_encoder_seq_pkg::*;
(
    input  logic [7:0] vec,
    input  logic [2:0] start,
    output logic [2:0] idx,
    output logic       found
);

`ifdef ROUND_ROBIN_EN
    logic [2:0] pos;

    // Walk offsets from farthest to nearest so the nearest set bit at or after start wins.
    always_comb begin
        idx   = 3'd0;
        found = 1'b0;
        pos   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            pos = start + 3'(k);
            if (vec[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end
`else
    logic unused_start;
    assign unused_start = ^start;

    // Ascending scan with last-hit-wins gives highest-index priority.
    always_comb begin
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/eight_to_three_encoder_seq.sv
// Sequential 8-to-3 encoder: accepts a request vector and emits the index of each set bit, one per handshake.
// Build option: ROUND_ROBIN_EN enables round-robin order with a persistent last_idx register.
module eight_to_three_encoder_seq
    import eight_to_three_encoder_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    eight_to_three_encoder_seq_if.slave bus
);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   pending_q, pending_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              code_valid_q, code_valid_d;
    logic [2:0]        search_start;
    logic [2:0]        found_idx;
    logic              found;

`ifdef ROUND_ROBIN_EN
    logic [2:0] last_idx_q, last_idx_d;
    assign search_start = last_idx_q + 3'd1;
`else
    assign search_start = 3'd7;
`endif

    prio_find8 u_find (
        .vec   (pending_q),
        .start (search_start),
        .idx   (found_idx),
        .found (found)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
`ifdef ROUND_ROBIN_EN
        last_idx_d   = last_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && (bus.req_in != '0)) begin
                    pending_d = bus.req_in;
                    state_d   = ST_ENCODE;
                end
            end
            ST_ENCODE: begin
                if (found) begin
                    code_d       = found_idx;
                    code_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (code_valid_q && bus.code_ready) begin
                    pending_d    = clear_bit(pending_q, code_q);
                    code_valid_d = 1'b0;
`ifdef ROUND_ROBIN_EN
                    last_idx_d   = code_q;
`endif
                    state_d      = (pending_d != '0) ? ST_ENCODE : ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                pending_d    = '0;
                code_valid_d = 1'b0;
            end
        endcase
    end

    // Reset drops any batch in flight; last_idx restarts so the first search begins at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_idx_q   <= 3'd7;
`endif
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
`ifdef ROUND_ROBIN_EN
            last_idx_q   <= last_idx_d;
`endif
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_eight_to_three_encoder_seq.sv
// Directed self-checking bench for eight_to_three_encoder_seq; expectations follow ROUND_ROBIN_EN when defined.
module tb_eight_to_three_encoder_seq;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    eight_to_three_encoder_seq_if bus ();

    eight_to_three_encoder_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance one clock and settle just past the edge; inputs and samples both happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] vec, input logic valid, input logic ready);
        bus.req_in     = vec;
        bus.req_valid  = valid;
        bus.code_ready = ready;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [2:0] exp_codes [4];
    logic [7:0] exp_pending;
    logic [2:0] first_code;
    logic [2:0] second_code;

    initial begin
        checks   = 0;
        failures = 0;
        applyStimulus(8'h00, 1'b0, 1'b0);

        // Test 1: reset state
        do_reset();
        checkOutput("rst_code_valid", 32'(bus.code_valid), 32'd0);
        checkOutput("rst_pending", 32'(bus.pending), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_code", 32'(bus.code), 32'd0);

        // Test 2: single bit, latency
        applyStimulus(8'b0000_1000, 1'b1, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        checkOutput("t2_encode_cv", 32'(bus.code_valid), 32'd0);
        checkOutput("t2_encode_busy", 32'(bus.busy), 32'd1);
        checkOutput("t2_encode_pending", 32'(bus.pending), 32'h08);
        tick();
        checkOutput("t2_cv", 32'(bus.code_valid), 32'd1);
        checkOutput("t2_code", 32'(bus.code), 32'd3);
        tick();
        checkOutput("t2_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("t2_idle_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("t2_idle_cv", 32'(bus.code_valid), 32'd0);
        checkOutput("t2_idle_pending", 32'(bus.pending), 32'd0);

        // Test 3: multi-bit batch from a fresh reset
        do_reset();
`ifdef ROUND_ROBIN_EN
        exp_codes = '{3'd0, 3'd2, 3'd5, 3'd7};
`else
        exp_codes = '{3'd7, 3'd5, 3'd2, 3'd0};
`endif
        exp_pending = 8'b1010_0101;
        applyStimulus(8'b1010_0101, 1'b1, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("t3_cv_%0d", k), 32'(bus.code_valid), 32'd1);
            checkOutput($sformatf("t3_code_%0d", k), 32'(bus.code), 32'(exp_codes[k]));
            checkOutput($sformatf("t3_pend_%0d", k), 32'(bus.pending), 32'(exp_pending));
            checkOutput($sformatf("t3_ready_%0d", k), 32'(bus.req_ready), 32'd0);
            tick();
            exp_pending[exp_codes[k]] = 1'b0;
            checkOutput($sformatf("t3_drop_cv_%0d", k), 32'(bus.code_valid), 32'd0);
            checkOutput($sformatf("t3_drop_pend_%0d", k), 32'(bus.pending), 32'(exp_pending));
            checkOutput($sformatf("t3_busy_%0d", k), 32'(bus.busy), (k < 3) ? 32'd1 : 32'd0);
        end
        checkOutput("t3_end_ready", 32'(bus.req_ready), 32'd1);

        // Test 4: stall in HOLD, plus a req_valid that must not be accepted
`ifdef ROUND_ROBIN_EN
        first_code  = 3'd0;
        second_code = 3'd7;
`else
        first_code  = 3'd7;
        second_code = 3'd0;
`endif
        applyStimulus(8'h81, 1'b1, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        checkOutput("t4_cv", 32'(bus.code_valid), 32'd1);
        checkOutput("t4_code", 32'(bus.code), 32'(first_code));
        applyStimulus(8'h10, 1'b1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            tick();
            checkOutput($sformatf("t4_stall_cv_%0d", s), 32'(bus.code_valid), 32'd1);
            checkOutput($sformatf("t4_stall_code_%0d", s), 32'(bus.code), 32'(first_code));
            checkOutput($sformatf("t4_stall_pend_%0d", s), 32'(bus.pending), 32'h81);
            checkOutput($sformatf("t4_stall_ready_%0d", s), 32'(bus.req_ready), 32'd0);
        end
        applyStimulus(8'h00, 1'b0, 1'b1);
        tick();
        checkOutput("t4_resume_pend", 32'(bus.pending), 32'(8'h81 & ~(8'h01 << first_code)));
        checkOutput("t4_resume_cv", 32'(bus.code_valid), 32'd0);
        tick();
        checkOutput("t4_second_cv", 32'(bus.code_valid), 32'd1);
        checkOutput("t4_second_code", 32'(bus.code), 32'(second_code));
        tick();
        checkOutput("t4_end_pend", 32'(bus.pending), 32'd0);
        checkOutput("t4_end_busy", 32'(bus.busy), 32'd0);

        // Test 5: empty vector is consumed with nothing emitted
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        checkOutput("t5_busy", 32'(bus.busy), 32'd0);
        checkOutput("t5_ready", 32'(bus.req_ready), 32'd1);
        tick();
        checkOutput("t5_cv", 32'(bus.code_valid), 32'd0);
        checkOutput("t5_pend", 32'(bus.pending), 32'd0);

        // Test 6: reset while holding a code
        applyStimulus(8'b0110_0000, 1'b1, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        checkOutput("t6_hold_cv", 32'(bus.code_valid), 32'd1);
        checkOutput("t6_hold_pend", 32'(bus.pending), 32'h60);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_rst_cv", 32'(bus.code_valid), 32'd0);
        checkOutput("t6_rst_pend", 32'(bus.pending), 32'd0);
        checkOutput("t6_rst_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("t6_rst_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
